// File: rtl/decade_cascade_ctrl_pkg.sv
// Shared types and constants for the cascaded BCD decade counter.
package decade_cascade_ctrl_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic digit_is_bcd(input logic [DIGIT_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/decade_digit.sv
// One BCD decade: clears or increments 0..9, with a ripple enable for the next digit.
module decade_digit
    import decade_cascade_ctrl_pkg::*;
(
    input  logic               clock,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    logic [DIGIT_W-1:0] q_d;
    logic [DIGIT_W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            // >= rather than == keeps the digit inside 0..9 even from an unexpected value
            q_d = (q_q >= BCD_MAX) ? '0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc && (q_q == BCD_MAX);

endmodule

// File: rtl/decade_cascade_ctrl.sv
// Run/pause/done controller around a chain of BCD decade digits with terminal compare.
module decade_cascade_ctrl
    import decade_cascade_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                      clock,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      clear,
    input  logic                      tick,
    input  logic                      auto_reload,
    input  logic [4*NUM_DIGITS-1:0]   limit,
    output logic [4*NUM_DIGITS-1:0]   count,
    output logic [1:0]                state,
    output logic                      running,
    output logic                      done,
    output logic                      limit_err
);

    state_e state_d;
    state_e state_q;
    logic   done_d;
    logic   done_q;

    logic                  start_ok;
    logic                  accept;
    logic                  terminal;
    logic                  digit_clr;
    logic [NUM_DIGITS:0]   inc_chain;
    logic                  unused_wrap;

    always_comb begin
        limit_err = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (!digit_is_bcd(limit[k*DIGIT_W +: DIGIT_W])) begin
                limit_err = 1'b1;
            end
        end
    end

    assign start_ok = start && !limit_err;
    assign accept   = tick && (state_q == RUN) && !stop && !clear;
    // count is always BCD, so an illegal limit can never match
    assign terminal = accept && (count == limit);

    assign inc_chain[0] = accept && !terminal;
    assign digit_clr    = clear
                       || (terminal && auto_reload)
                       || ((state_q == DONE) && start_ok && !stop);

    always_comb begin
        state_d = state_q;
        done_d  = terminal;
        if (clear) begin
            state_d = IDLE;
        end else if (stop) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
            end
        end else if (terminal && !auto_reload) begin
            state_d = DONE;
        end else if (start_ok) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        decade_digit u_digit (
            .clock (clock),
            .rst_n (rst_n),
            .clr   (digit_clr),
            .inc   (inc_chain[k]),
            .q     (count[k*DIGIT_W +: DIGIT_W]),
            .carry (inc_chain[k+1])
        );
    end

    // full-scale rollover needs no action: every digit already returned to zero
    assign unused_wrap = inc_chain[NUM_DIGITS];

    assign state   = state_q;
    assign running = (state_q == RUN);
    assign done    = done_q;

endmodule
